// File: rtl/dt_engine.sv
// Two-pass in-place distance transform (chessboard or city-block) over a binary image in external memory.
// Memory-bound: at most SW+2 cycles per source word in INIT and at most 7 cycles per pixel in each scan pass.
module dt_engine #(
  parameter int IMG_W = 128,
  parameter int IMG_H = 128,
  parameter int SW    = 16,
  parameter int DW    = 8,
  localparam int NPIX = IMG_W * IMG_H,
  localparam int AW   = $clog2(NPIX),
  localparam int NWRD = NPIX / SW,
  localparam int WAW  = (NWRD > 1) ? $clog2(NWRD) : 1
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  input  logic           mode,
  output logic           busy,
  output logic           done,
  output logic           sti_rd,
  output logic [WAW-1:0] sti_addr,
  input  logic [SW-1:0]  sti_di,
  output logic           res_rd,
  output logic           res_wr,
  output logic [AW-1:0]  res_addr,
  output logic [DW-1:0]  res_do,
  input  logic [DW-1:0]  res_di
);

  localparam int CW  = $clog2(IMG_W);
  localparam int RW  = $clog2(IMG_H);
  localparam int BCW = $clog2(SW) + 1;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_INIT = 3'd1;
  localparam logic [2:0] S_FWD  = 3'd2;
  localparam logic [2:0] S_BWD  = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  localparam logic [2:0] P_RD   = 3'd0;
  localparam logic [2:0] P_WT   = 3'd1;
  localparam logic [2:0] P_SELF = 3'd2;
  localparam logic [2:0] P_NB   = 3'd3;
  localparam logic [2:0] P_FL   = 3'd4;
  localparam logic [2:0] I_RD   = 3'd5;
  localparam logic [2:0] I_WT   = 3'd6;
  localparam logic [2:0] I_WR   = 3'd7;

  localparam logic [DW:0]     MAXV     = {1'b0, {DW{1'b1}}};
  localparam logic [AW-1:0]   PIX_LAST = AW'(NPIX - 1);
  localparam logic [AW-1:0]   ROW_STEP = AW'(IMG_W);
  localparam logic [WAW-1:0]  WD_LAST  = WAW'(NWRD - 1);
  localparam logic [BCW-1:0]  BC_LAST  = BCW'(SW - 1);
  localparam logic [CW-1:0]   COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0]   ROW_LAST = RW'(IMG_H - 1);

  logic [2:0]     state_q, state_d;
  logic [2:0]     ps_q, ps_d;
  logic           mode_q, mode_d;
  logic [AW-1:0]  pix_q, pix_d;
  logic [WAW-1:0] wd_q, wd_d;
  logic [BCW-1:0] bc_q, bc_d;
  logic [1:0]     nk_q, nk_d;
  logic [SW-1:0]  sh_q, sh_d;
  logic [DW:0]    min_q, min_d;
  logic [DW-1:0]  self_q, self_d;
  logic [DW-1:0]  last_q, last_d;
  logic           sti_rd_q, sti_rd_d;
  logic [WAW-1:0] sti_addr_q, sti_addr_d;
  logic           res_rd_q, res_rd_d;
  logic           res_wr_q, res_wr_d;
  logic [AW-1:0]  res_addr_q, res_addr_d;
  logic [DW-1:0]  res_do_q, res_do_d;

  logic           chess, fwd, edge_out;
  logic [CW-1:0]  col;
  logic [RW-1:0]  row;
  logic [1:0]     nb_cnt, nb_sel;
  logic [AW-1:0]  nb_base, nb_addr;
  logic [DW:0]    nb_val, min_fold, inc;
  logic [DW-1:0]  sat, nb_res;
  logic [SW-1:0]  src;
  logic           pix_done, pix_wr;
  logic [DW-1:0]  pix_val;

  assign chess = ~mode_q;
  assign fwd   = (state_q == S_FWD);
  assign col   = pix_q[CW-1:0];
  assign row   = pix_q[AW-1:CW];

  // Any out-of-image neighbour forces the minimum to 0, so such pixels need no neighbour reads.
  assign edge_out = fwd ? ((row == '0) || (col == '0) || (chess && (col == COL_LAST)))
                        : ((row == ROW_LAST) || (col == COL_LAST) || (chess && (col == '0)));

  assign nb_cnt  = chess ? 2'd3 : 2'd1;
  assign nb_sel  = (ps_q == P_SELF) ? 2'd0 : nk_q + 2'd1;
  assign nb_base = fwd ? pix_q - ROW_STEP : pix_q + ROW_STEP;
  assign nb_addr = chess ? nb_base - AW'(1) + AW'(nb_sel) : nb_base;

  // The W (fwd) / E (bwd) neighbour is the previous pixel of the scan, held in last_q.
  assign nb_val   = {1'b0, res_di};
  assign min_fold = ((nk_q != 2'd0) && (nb_val < min_q)) ? nb_val : min_q;
  assign inc      = min_fold + (DW+1)'(1);
  assign sat      = (inc > MAXV) ? MAXV[DW-1:0] : inc[DW-1:0];
  assign nb_res   = (!fwd && (self_q < sat)) ? self_q : sat;
  assign src      = (bc_q == '0) ? sti_di : sh_q;

  always_comb begin
    state_d    = state_q;
    ps_d       = ps_q;
    mode_d     = mode_q;
    pix_d      = pix_q;
    wd_d       = wd_q;
    bc_d       = bc_q;
    nk_d       = nk_q;
    sh_d       = sh_q;
    min_d      = min_q;
    self_d     = self_q;
    last_d     = last_q;
    sti_rd_d   = 1'b0;
    sti_addr_d = sti_addr_q;
    res_rd_d   = 1'b0;
    res_wr_d   = 1'b0;
    res_addr_d = res_addr_q;
    res_do_d   = res_do_q;
    pix_done   = 1'b0;
    pix_wr     = 1'b0;
    pix_val    = '0;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_INIT;
          ps_d    = I_RD;
          mode_d  = mode;
          pix_d   = '0;
          wd_d    = '0;
        end
      end
      S_INIT: begin
        case (ps_q)
          I_RD: begin
            sti_rd_d   = 1'b1;
            sti_addr_d = wd_q;
            bc_d       = '0;
            ps_d       = I_WT;
          end
          I_WT: ps_d = I_WR;
          default: begin
            sh_d       = src << 1;
            res_wr_d   = 1'b1;
            res_addr_d = pix_q;
            res_do_d   = DW'(src[SW-1]);
            pix_d      = pix_q + AW'(1);
            bc_d       = bc_q + BCW'(1);
            if (bc_q == BC_LAST) begin
              wd_d = wd_q + WAW'(1);
              if (wd_q == WD_LAST) begin
                state_d = S_FWD;
                ps_d    = P_RD;
              end else begin
                ps_d = I_RD;
              end
            end else begin
              ps_d = I_WR;
            end
          end
        endcase
      end
      S_FWD, S_BWD: begin
        case (ps_q)
          P_RD: begin
            res_rd_d   = 1'b1;
            res_addr_d = pix_q;
            ps_d       = P_WT;
          end
          P_WT: ps_d = P_SELF;
          P_SELF: begin
            if (res_di == '0) begin
              pix_done = 1'b1;
            end else begin
              self_d = res_di;
              if (edge_out || (last_q == '0)) begin
                pix_done = 1'b1;
                pix_wr   = 1'b1;
                pix_val  = DW'(1);
              end else begin
                min_d      = {1'b0, last_q};
                nk_d       = 2'd0;
                res_rd_d   = 1'b1;
                res_addr_d = nb_addr;
                ps_d       = P_NB;
              end
            end
          end
          P_NB: begin
            // Reads are back to back; data for neighbour k arrives while nk_q == k+1.
            min_d = min_fold;
            if (nk_q == nb_cnt) begin
              pix_done = 1'b1;
              pix_wr   = 1'b1;
              pix_val  = nb_res;
            end else begin
              if (nk_q != nb_cnt - 2'd1) begin
                res_rd_d   = 1'b1;
                res_addr_d = nb_addr;
              end
              nk_d = nk_q + 2'd1;
            end
          end
          P_FL: state_d = S_DONE;
          default: ;
        endcase
      end
      default: state_d = S_IDLE;
    endcase

    if (pix_done) begin
      last_d = pix_wr ? pix_val : '0;
      if (pix_wr) begin
        res_wr_d   = 1'b1;
        res_addr_d = pix_q;
        res_do_d   = pix_val;
      end
      ps_d = P_RD;
      if (fwd) begin
        if (pix_q == PIX_LAST) state_d = S_BWD;
        else                   pix_d   = pix_q + AW'(1);
      end else if (pix_q == '0) begin
        // Let the final write complete before signalling done.
        if (pix_wr) ps_d    = P_FL;
        else        state_d = S_DONE;
      end else begin
        pix_d = pix_q - AW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      ps_q       <= P_RD;
      mode_q     <= 1'b0;
      pix_q      <= '0;
      wd_q       <= '0;
      bc_q       <= '0;
      nk_q       <= '0;
      sh_q       <= '0;
      min_q      <= '0;
      self_q     <= '0;
      last_q     <= '0;
      sti_rd_q   <= 1'b0;
      sti_addr_q <= '0;
      res_rd_q   <= 1'b0;
      res_wr_q   <= 1'b0;
      res_addr_q <= '0;
      res_do_q   <= '0;
    end else begin
      state_q    <= state_d;
      ps_q       <= ps_d;
      mode_q     <= mode_d;
      pix_q      <= pix_d;
      wd_q       <= wd_d;
      bc_q       <= bc_d;
      nk_q       <= nk_d;
      sh_q       <= sh_d;
      min_q      <= min_d;
      self_q     <= self_d;
      last_q     <= last_d;
      sti_rd_q   <= sti_rd_d;
      sti_addr_q <= sti_addr_d;
      res_rd_q   <= res_rd_d;
      res_wr_q   <= res_wr_d;
      res_addr_q <= res_addr_d;
      res_do_q   <= res_do_d;
    end
  end

  assign busy     = (state_q == S_INIT) || (state_q == S_FWD) || (state_q == S_BWD);
  assign done     = (state_q == S_DONE);
  assign sti_rd   = sti_rd_q;
  assign sti_addr = sti_addr_q;
  assign res_rd   = res_rd_q;
  assign res_wr   = res_wr_q;
  assign res_addr = res_addr_q;
  assign res_do   = res_do_q;

endmodule

// File: tb/tb_dt_engine.sv
// Bench for dt_engine: 8x8 image, SW=8, one instance with DW=8 and one with DW=2 run side by side.
module tb_dt_engine;

  localparam int W = 8;
  localparam int H = 8;

  logic clk = 1'b0;
  logic reset, start, mode;

  logic       busy_a, done_a, sti_rd_a, res_rd_a, res_wr_a;
  logic [2:0] sti_addr_a;
  logic [7:0] sti_di_a;
  logic [5:0] res_addr_a;
  logic [7:0] res_do_a, res_di_a;

  logic       busy_b, done_b, sti_rd_b, res_rd_b, res_wr_b;
  logic [2:0] sti_addr_b;
  logic [7:0] sti_di_b;
  logic [5:0] res_addr_b;
  logic [1:0] res_do_b, res_di_b;

  logic [7:0] src_mem [8];
  logic [7:0] mem_a [64];
  logic [1:0] mem_b [64];

  dt_engine #(.IMG_W(8), .IMG_H(8), .SW(8), .DW(8)) u_dut_a (
    .clk(clk), .reset(reset), .start(start), .mode(mode),
    .busy(busy_a), .done(done_a),
    .sti_rd(sti_rd_a), .sti_addr(sti_addr_a), .sti_di(sti_di_a),
    .res_rd(res_rd_a), .res_wr(res_wr_a), .res_addr(res_addr_a),
    .res_do(res_do_a), .res_di(res_di_a)
  );

  dt_engine #(.IMG_W(8), .IMG_H(8), .SW(8), .DW(2)) u_dut_b (
    .clk(clk), .reset(reset), .start(start), .mode(mode),
    .busy(busy_b), .done(done_b),
    .sti_rd(sti_rd_b), .sti_addr(sti_addr_b), .sti_di(sti_di_b),
    .res_rd(res_rd_b), .res_wr(res_wr_b), .res_addr(res_addr_b),
    .res_do(res_do_b), .res_di(res_di_b)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (sti_rd_a) sti_di_a <= src_mem[sti_addr_a];
    if (sti_rd_b) sti_di_b <= src_mem[sti_addr_b];
    if (res_wr_a) mem_a[res_addr_a] <= res_do_a;
    if (res_rd_a) res_di_a <= mem_a[res_addr_a];
    if (res_wr_b) mem_b[res_addr_b] <= res_do_b;
    if (res_rd_b) res_di_b <= mem_b[res_addr_b];
  end

  int nvec = 0;
  int nmis = 0;

  typedef struct { int inst; int addr; int val; } exp_t;
  exp_t sbq[$];
  int mdl [64];

  typedef struct {
    string       name;
    logic [63:0] img;
    logic        md;
    int          sum_a;
    int          sum_b;
    int          poke;
  } vec_t;

  task automatic chk(input string nm, input int act, input int exp);
    nvec++;
    if (act != exp) begin
      nmis++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  function automatic int imin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  function automatic int nb(input int r, input int c);
    if (r < 0 || r >= H || c < 0 || c >= W) return 0;
    return mdl[r*W + c];
  endfunction

  function automatic logic [63:0] rect(input int r0, input int r1, input int c0, input int c1);
    logic [63:0] v;
    v = '0;
    for (int r = r0; r <= r1; r++)
      for (int c = c0; c <= c1; c++) v[r*W + c] = 1'b1;
    return v;
  endfunction

  // Reference two-pass transform straight from the pass definitions (out-of-image reads as 0).
  task automatic build_model(input logic [63:0] img, input logic md, input int maxv, input int inst);
    int m;
    exp_t e;
    for (int p = 0; p < 64; p++) mdl[p] = img[p] ? 1 : 0;
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        if (mdl[r*W + c] != 0) begin
          m = imin(nb(r-1, c), nb(r, c-1));
          if (!md) m = imin(m, imin(nb(r-1, c-1), nb(r-1, c+1)));
          mdl[r*W + c] = imin(m + 1, maxv);
        end
    for (int r = H-1; r >= 0; r--)
      for (int c = W-1; c >= 0; c--)
        if (mdl[r*W + c] != 0) begin
          m = imin(nb(r, c+1), nb(r+1, c));
          if (!md) m = imin(m, imin(nb(r+1, c-1), nb(r+1, c+1)));
          mdl[r*W + c] = imin(mdl[r*W + c], imin(m + 1, maxv));
        end
    for (int p = 0; p < 64; p++) begin
      e.inst = inst; e.addr = p; e.val = mdl[p];
      sbq.push_back(e);
    end
  endtask

  task automatic load_src(input logic [63:0] img);
    logic [7:0] wv;
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) wv[7-c] = img[r*W + c];
      src_mem[r] = wv;
    end
  endtask

  task automatic run_img(input vec_t v);
    int wr_a, wr_b, srd_a, srd_b, clash, ones, s_a, s_b, act;
    bit seen_a, seen_b;
    exp_t e;
    wr_a = 0; wr_b = 0; srd_a = 0; srd_b = 0; clash = 0; s_a = 0; s_b = 0;
    seen_a = 0; seen_b = 0;
    ones = $countones(v.img);
    load_src(v.img);
    build_model(v.img, v.md, 255, 0);
    build_model(v.img, v.md, 3, 1);

    @(negedge clk); start = 1'b1; mode = v.md;
    @(negedge clk); start = 1'b0; mode = ~v.md;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(posedge clk); #1;
      if (sti_rd_a) srd_a++;
      if (sti_rd_b) srd_b++;
      if (res_wr_a) wr_a++;
      if (res_wr_b) wr_b++;
      if (int'(sti_rd_a) + int'(res_rd_a) + int'(res_wr_a) > 1) clash++;
      if (int'(sti_rd_b) + int'(res_rd_b) + int'(res_wr_b) > 1) clash++;
      if (done_a) seen_a = 1;
      if (done_b) seen_b = 1;
      if (seen_a && seen_b) break;
      if (v.poke > 0 && cyc == v.poke) begin
        chk({v.name, " busy when start poked"}, int'(busy_a), 1);
        start = 1'b1;
      end
      if (v.poke > 0 && cyc == v.poke + 1) start = 1'b0;
    end
    start = 1'b0;
    chk({v.name, " done_a reached"}, int'(seen_a), 1);
    chk({v.name, " done_b reached"}, int'(seen_b), 1);
    chk({v.name, " busy_a low at done"}, int'(busy_a), 0);
    chk({v.name, " source reads a"}, srd_a, 8);
    chk({v.name, " source reads b"}, srd_b, 8);
    chk({v.name, " result writes a"}, wr_a, 64 + 2*ones);
    chk({v.name, " result writes b"}, wr_b, 64 + 2*ones);
    chk({v.name, " strobe overlap"}, clash, 0);
    repeat (3) @(posedge clk);
    #1;
    chk({v.name, " done held"}, int'(done_a) + int'(done_b), 2);
    while (sbq.size() > 0) begin
      e = sbq.pop_front();
      act = (e.inst == 0) ? int'(mem_a[e.addr]) : int'(mem_b[e.addr]);
      if (e.inst == 0) s_a += act; else s_b += act;
      chk($sformatf("%s px%0d inst%0d", v.name, e.addr, e.inst), act, e.val);
    end
    chk({v.name, " sum a"}, s_a, v.sum_a);
    chk({v.name, " sum b"}, s_b, v.sum_b);
  endtask

  task automatic reset_mid_run();
    bit in_fwd;
    in_fwd = 0;
    load_src(rect(2, 4, 3, 3) | rect(3, 3, 2, 4));
    @(negedge clk); start = 1'b1; mode = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int cyc = 0; cyc < 500; cyc++) begin
      @(posedge clk); #1;
      if (res_rd_a) begin in_fwd = 1; break; end
    end
    chk("reset test reached FWD", int'(in_fwd), 1);
    repeat (7) @(posedge clk);
    #3 reset = 1'b0;
    #1;
    chk("reset status a", int'({busy_a, done_a}), 0);
    chk("reset status b", int'({busy_b, done_b}), 0);
    chk("reset mem outputs a", int'({sti_rd_a, res_rd_a, res_wr_a, sti_addr_a, res_addr_a, res_do_a}), 0);
    chk("reset mem outputs b", int'({sti_rd_b, res_rd_b, res_wr_b, sti_addr_b, res_addr_b, res_do_b}), 0);
    repeat (3) @(posedge clk);
    #1;
    chk("no access in reset", int'({sti_rd_a, res_rd_a, res_wr_a, sti_rd_b, res_rd_b, res_wr_b}), 0);
    @(negedge clk); reset = 1'b1;
  endtask

  initial begin
    vec_t vt [10];
    vec_t after_rst;
    logic [63:0] plus_img, ones_img, one_img, sq_img;
    plus_img = rect(2, 4, 3, 3) | rect(3, 3, 2, 4);
    ones_img = rect(0, 7, 0, 7);
    one_img  = rect(3, 3, 3, 3);
    sq_img   = rect(2, 5, 2, 5);
    vt[0] = '{"all-zero",     64'h0,    1'b0,   0,   0,   0};
    vt[1] = '{"single m0",    one_img,  1'b0,   1,   1,   0};
    vt[2] = '{"single m1",    one_img,  1'b1,   1,   1,   0};
    vt[3] = '{"plus m0",      plus_img, 1'b0,   5,   5,   0};
    vt[4] = '{"plus m1",      plus_img, 1'b1,   6,   6,   0};
    vt[5] = '{"all-ones m0",  ones_img, 1'b0, 120, 116,   0};
    vt[6] = '{"all-ones m1",  ones_img, 1'b1, 120, 116,   0};
    vt[7] = '{"square m1",    sq_img,   1'b1,  20,  20,   0};
    vt[8] = '{"plus m0 poke", plus_img, 1'b0,   5,   5, 200};
    vt[9] = '{"plus m1 redo", plus_img, 1'b1,   6,   6,   0};
    after_rst = '{"plus m1 after reset", plus_img, 1'b1, 6, 6, 0};

    reset = 1'b0; start = 1'b0; mode = 1'b0;
    #12;
    chk("initial status a", int'({busy_a, done_a}), 0);
    chk("initial mem outputs a", int'({sti_rd_a, res_rd_a, res_wr_a, sti_addr_a, res_addr_a, res_do_a}), 0);
    chk("initial status b", int'({busy_b, done_b}), 0);
    @(negedge clk); reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("idle without start", int'({busy_a, done_a, busy_b, done_b}), 0);

    for (int i = 0; i < 10; i++) run_img(vt[i]);

    reset_mid_run();
    run_img(after_rst);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule

// File: doc/dt_engine.md
DT_ENGINE -- requirements
Module: dt_engine

Interface
REQ-001 Parameter IMG_W, default 128, image width in pixels, power of 2, 4..256.
REQ-002 Parameter IMG_H, default 128, image height in pixels, power of 2, 4..256.
REQ-003 Parameter SW, default 16, source word width in bits; power of 2; SW ≤ IMG_W.
REQ-004 Parameter DW, default 8, distance value width in bits, 2..16.
REQ-005 Clock and reset: reset is asynchronous, active-low; clock is clk.
REQ-006 clk  in  1  rising-edge clock.
REQ-007 reset  in  1  asynchronous active-low reset.
REQ-008 start  in  1  single-cycle request to begin a transform; honoured only in IDLE or DONE.
REQ-009 mode  in  1  metric, sampled with start: 0 = chessboard (8-neighbour), 1 = city-block (4-neighbour).
REQ-010 busy  out  1  high in INIT, FWD and BWD.
REQ-011 done  out  1  high while in DONE.
REQ-012 sti_rd, sti_addr  out  1, log2(IMG_W*IMG_H/SW)  source-memory read strobe and word address.
REQ-013 sti_di  in  SW  source word, valid the cycle after sti_rd; MSB = lowest pixel index in raster order.
REQ-014 res_rd, res_wr, res_addr  out  1, 1, log2(IMG_W*IMG_H)  result-memory strobes; address = row*IMG_W+col.
REQ-015 res_do  out  DW  write data; res_di  in  DW  read data, valid the cycle after res_rd.

Function
REQ-016 FSM states IDLE, INIT, FWD, BWD, DONE; IDLE->INIT on start; INIT->FWD, FWD->BWD and BWD->DONE each after the last pixel of the phase; DONE->INIT on start; DONE otherwise holds.
REQ-017 start is ignored while busy; mode is latched on the accepted start and held constant for the whole run.
REQ-018 sti_rd, res_rd and res_wr are never asserted together; at most one memory access per cycle; all memory outputs are driven from registers.
REQ-019 INIT reads each source word once in ascending address order; for each bit it writes res = 1 if the bit is set, else 0, in ascending pixel order.
REQ-020 FWD scans pixels in raster order (row 0 col 0 first); a pixel whose value is 0 is read once and not written.
REQ-021 FWD, nonzero pixel: res = sat(min(neighbours)+1); chessboard neighbours NW, N, NE, W; city-block neighbours N, W.
REQ-022 BWD scans pixels in reverse raster order; a pixel whose value is 0 is read once and not written.
REQ-023 BWD, nonzero pixel: res = min(self, sat(min(neighbours)+1)); chessboard neighbours E, SW, S, SE; city-block neighbours E, S.
REQ-024 Neighbours outside the image read as 0 without any memory access; no address wrap-around between rows.
REQ-025 sat(x) clamps to 2^DW-1; all arithmetic uses DW+1 bits internally; no result wraps.
REQ-026 Each FWD or BWD pixel takes at most 7 cycles; INIT takes at most SW+2 cycles per source word.
REQ-027 A pixel's write completes before the first read of the next pixel; in-place results are therefore visible to later neighbours in the same pass.
REQ-028 done asserts the cycle after the final BWD write (or final BWD read if that pixel is 0); busy deasserts in the same cycle.

Reset
REQ-029 Reset low: FSM to IDLE; busy, done, sti_rd, res_rd and res_wr = 0; sti_addr, res_addr and res_do = 0; latched mode = 0.
REQ-030 Reset mid-run aborts immediately with no further memory access; result-memory contents are undefined until the next completed run.

Verification (IMG_W = IMG_H = 8, SW = 8, DW = 8 unless stated)
REQ-031 All-zero image -> every res = 0; done rises; no res_wr occurs during FWD or BWD.
REQ-032 Single object pixel at (3,3), either mode -> res(3,3) = 1, all other pixels 0.
REQ-033 Plus shape {(2,3),(3,2),(3,3),(3,4),(4,3)}, mode 0 -> center = 1, arms = 1; mode 1 -> center = 2, arms = 1.
REQ-034 All-ones image, DW = 2, mode 0 -> border ring = 1, next ring = 2, inner rings = 3 (center value 4 saturated to 3).
REQ-035 Reset pulsed during FWD -> all outputs 0 the same cycle; busy = 0 and done = 0; a subsequent start yields the correct result for REQ-033.
REQ-036 start pulsed while busy -> ignored and no restart; start pulsed in DONE with the other mode -> new run, and results match that mode.
